// File: rtl/vfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vfx_pkg
//  Purpose  : Shared types, default constants and mode-cycling helpers for the
//             video effect pipeline control blocks.
//  Contents : ctrl_state_t      - mode-select FSM state encoding
//             VFX_NUM_MODES     - default number of filter modes
//             VFX_DEFAULT_MODE  - default filter mode after reset
//             wrap_inc/wrap_dec - modular step through 0..num-1
//  Revision : 1.0 - initial release
// ============================================================================
package vfx_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ctrl_state_t;

  localparam int VFX_NUM_MODES    = 8;
  localparam int VFX_DEFAULT_MODE = 0;

  // Step forward, wrapping the last mode back to 0.
  function automatic int wrap_inc(input int val, input int num);
    return (val >= num - 1) ? 0 : val + 1;
  endfunction

  // Step backward, wrapping 0 to the last mode.
  function automatic int wrap_dec(input int val, input int num);
    return (val == 0) ? num - 1 : val - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/effect_mode_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : effect_mode_controller_if
//  Purpose  : Bundles the button/frame inputs and the mode outputs of the
//             effect mode controller.
//  Ports    : btn_next, btn_prev  raw push-buttons (master -> slave)
//             frame_start         frame boundary pulse (master -> slave)
//             mode, pending_mode  committed / awaiting mode (slave -> master)
//             pending, mode_update change-pending flag, commit pulse
//  Revision : 1.0 - initial release
// ============================================================================
interface effect_mode_controller_if #(
  parameter int MW = 3
);
  logic          btn_next;
  logic          btn_prev;
  logic          frame_start;
  logic [MW-1:0] mode;
  logic [MW-1:0] pending_mode;
  logic          pending;
  logic          mode_update;

  modport master (
    output btn_next, btn_prev, frame_start,
    input  mode, pending_mode, pending, mode_update
  );

  modport slave (
    input  btn_next, btn_prev, frame_start,
    output mode, pending_mode, pending, mode_update
  );
endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Two-flop synchroniser, stability-counter debounce and registered
//             rising-edge detector for one raw push-button.
//  Ports    : clk, reset (async, active-high)
//             raw    - asynchronous button level
//             level  - debounced level
//             press  - one-cycle pulse on debounced rising edge
//  Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic raw,
  output logic      level,
  output logic      press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_meta;
  logic          sync_out;
  logic [CW-1:0] stable_cnt;
  logic          level_q;
  logic          level_dly;
  logic          press_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_out   <= 1'b0;
      stable_cnt <= '0;
      level_q    <= 1'b0;
      level_dly  <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
      // Any cycle that agrees with the accepted level restarts the count, so
      // only an uninterrupted run of disagreeing samples flips the level.
      if (sync_out == level_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q    <= ~level_q;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
      level_dly <= level_q;
      press_q   <= level_q & ~level_dly;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/effect_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module   : effect_mode_controller
//  Purpose  : Turns next/prev button presses into filter-mode changes that are
//             held pending and committed only on a frame boundary. A long hold
//             of btn_next forces the default mode.
//  Ports    : clk, reset (async, active-high)
//             bus (slave) - btn_next, btn_prev, frame_start in;
//                           mode, pending_mode, pending, mode_update out
//  Revision : 1.0 - initial release
// ============================================================================
module effect_mode_controller
  import vfx_pkg::*;
#(
  parameter int NUM_MODES         = VFX_NUM_MODES,
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int DEFAULT_MODE      = VFX_DEFAULT_MODE
) (
  input wire logic                clk,
  input wire logic                reset,
  effect_mode_controller_if.slave bus
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  logic          next_level;
  logic          next_press;
  logic          prev_press;
  logic          unused_prev_level;

  ctrl_state_t   state;
  logic [MW-1:0] committed_mode;
  logic [MW-1:0] pend_mode;
  logic          pend_flag;
  logic          update_pulse;
  logic [HW-1:0] hold_cnt;
  logic          long_pulse;

  logic          event_valid;
  logic [MW-1:0] base_mode;
  logic [MW-1:0] target_mode;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_next),
    .level (next_level),
    .press (next_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_prev),
    .level (unused_prev_level),
    .press (prev_press)
  );

  // Simultaneous next+prev cancel each other; a long press wins over both.
  // In PENDING the base is pending_mode, which is also the value committed
  // when frame_start coincides with a press.
  always_comb begin
    event_valid = (next_press ^ prev_press) | long_pulse;
    base_mode   = (state == PENDING) ? pend_mode : committed_mode;
    if (long_pulse) begin
      target_mode = MW'(DEFAULT_MODE);
    end else if (next_press) begin
      target_mode = MW'(wrap_inc(32'(base_mode), NUM_MODES));
    end else begin
      target_mode = MW'(wrap_dec(32'(base_mode), NUM_MODES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      committed_mode <= MW'(DEFAULT_MODE);
      pend_mode      <= MW'(DEFAULT_MODE);
      pend_flag      <= 1'b0;
      update_pulse   <= 1'b0;
      hold_cnt       <= '0;
      long_pulse     <= 1'b0;
    end else begin
      update_pulse <= 1'b0;

      // Saturating hold counter: fires exactly once per continuous hold.
      if (!next_level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HW'(LONG_PRESS_CYCLES)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      long_pulse <= next_level && (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));

      case (state)
        IDLE: begin
          // frame_start has nothing to commit here; a press only goes pending.
          if (event_valid) begin
            pend_mode <= target_mode;
            pend_flag <= 1'b1;
            state     <= PENDING;
          end
        end
        PENDING: begin
          if (bus.frame_start) begin
            committed_mode <= pend_mode;
            update_pulse   <= 1'b1;
            if (!event_valid) begin
              pend_flag <= 1'b0;
              state     <= IDLE;
            end
          end
          if (event_valid) begin
            pend_mode <= target_mode;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mode         = committed_mode;
  assign bus.pending_mode = pend_mode;
  assign bus.pending      = pend_flag;
  assign bus.mode_update  = update_pulse;

endmodule
`default_nettype wire
